// File: rtl/legv8_pkg.sv
// Shared constants and types for the LEGv8 boot/debug controller.
package legv8_pkg;

    localparam int PC_W_DEF    = 8;
    localparam int INSTR_W_DEF = 16;
    localparam int BYTE_W      = 8;
    localparam int RUN_CNT_W   = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_HI = 3'd1,
        ST_LOAD_LO = 3'd2,
        ST_WRITE   = 3'd3,
        ST_RELEASE = 3'd4,
        ST_HALT    = 3'd5,
        ST_RUN     = 3'd6,
        ST_STEP    = 3'd7
    } boot_state_e;

    // Saturating increment for the enabled-cycle counter.
    function automatic logic [RUN_CNT_W-1:0] sat_inc(input logic [RUN_CNT_W-1:0] v);
        return (v == {RUN_CNT_W{1'b1}}) ? v : v + RUN_CNT_W'(1);
    endfunction

endpackage

// File: rtl/core_boot_ctrl.sv
// Boot loader and run/halt/step debug controller for a small core.
// Loads big-endian byte pairs into instruction memory, then releases the
// core and gates its clock enable under host control with a PC breakpoint.
module core_boot_ctrl
    import legv8_pkg::*;
#(
    parameter int IMEM_AW = 4,
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int PC_W    = PC_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_start,
    input  logic [IMEM_AW-1:0]   load_len,
    input  logic                 in_valid,
    input  logic [BYTE_W-1:0]    in_data,
    output logic                 in_ready,
    output logic                 imem_we,
    output logic [IMEM_AW-1:0]   imem_waddr,
    output logic [INSTR_W-1:0]   imem_wdata,
    input  logic                 run_req,
    input  logic                 halt_req,
    input  logic                 step_req,
    input  logic                 bp_en,
    input  logic [PC_W-1:0]      bp_addr,
    input  logic [PC_W-1:0]      core_pc,
    output logic                 core_rst,
    output logic                 core_clk_en,
    output logic                 loaded,
    output logic                 bp_hit,
    output logic [RUN_CNT_W-1:0] run_cycles
);

    localparam logic [IMEM_AW-1:0] ADDR_ONE = IMEM_AW'(1);

    boot_state_e            state, state_nxt;
    logic [IMEM_AW-1:0]     len_q;
    logic [IMEM_AW-1:0]     waddr_q;
    logic [INSTR_W-1:0]     wdata_q;
    logic                   run_first_q;
    logic                   bp_hit_q;
    logic [RUN_CNT_W-1:0]   run_cnt_q;

    logic byte_hs;
    logic last_word;
    logic start_load;
    logic bp_stop;
    logic core_req_ok;

    // len 0 wraps to all-ones here, which is exactly the 2^AW-word case.
    assign last_word  = (waddr_q == (len_q - ADDR_ONE));
    assign byte_hs    = in_valid && in_ready;
    // load_start is only honoured from IDLE or HALT, where it has top priority.
    assign start_load = load_start && ((state == ST_IDLE) || (state == ST_HALT));
    // Breakpoint is masked on the first RUN cycle so a resume from the
    // breakpoint PC can execute that instruction.
    assign bp_stop    = (state == ST_RUN) && bp_en && (core_pc == bp_addr) && !run_first_q;
    // A step or run request accepted out of HALT (load_start outranks both).
    assign core_req_ok = (state == ST_HALT) && !load_start && (step_req || run_req);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (load_start) state_nxt = ST_LOAD_HI;
            ST_LOAD_HI: if (byte_hs)    state_nxt = ST_LOAD_LO;
            ST_LOAD_LO: if (byte_hs)    state_nxt = ST_WRITE;
            ST_WRITE:   state_nxt = last_word ? ST_RELEASE : ST_LOAD_HI;
            ST_RELEASE: state_nxt = ST_HALT;
            ST_HALT: begin
                if (load_start)    state_nxt = ST_LOAD_HI;
                else if (step_req) state_nxt = ST_STEP;
                else if (run_req)  state_nxt = ST_RUN;
            end
            ST_RUN:     if (bp_stop || halt_req) state_nxt = ST_HALT;
            ST_STEP:    state_nxt = ST_HALT;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Output decode from state plus the breakpoint comparator.
    always_comb begin
        core_rst    = 1'b1;
        core_clk_en = 1'b0;
        in_ready    = 1'b0;
        imem_we     = 1'b0;
        loaded      = 1'b0;
        case (state)
            ST_LOAD_HI, ST_LOAD_LO: in_ready = 1'b1;
            ST_WRITE:               imem_we  = 1'b1;
            ST_HALT: begin
                core_rst = 1'b0;
                loaded   = 1'b1;
            end
            ST_RUN: begin
                core_rst    = 1'b0;
                loaded      = 1'b1;
                core_clk_en = !bp_stop;
            end
            ST_STEP: begin
                core_rst    = 1'b0;
                loaded      = 1'b1;
                core_clk_en = 1'b1;
            end
            default: ;
        endcase
    end

    // Load datapath: word address, latched length and assembled instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q   <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else if (start_load) begin
            len_q   <= load_len;
            waddr_q <= '0;
        end else begin
            case (state)
                ST_LOAD_HI: if (byte_hs) wdata_q[INSTR_W-1 -: BYTE_W] <= in_data;
                ST_LOAD_LO: if (byte_hs) wdata_q[BYTE_W-1:0]          <= in_data;
                ST_WRITE:   if (!last_word) waddr_q <= waddr_q + ADDR_ONE;
                default: ;
            endcase
        end
    end

    // Remember whether the previous cycle was already RUN (breakpoint mask).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) run_first_q <= 1'b1;
        else     run_first_q <= (state != ST_RUN);
    end

    // Sticky breakpoint flag, cleared on release or on the next accepted request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                    bp_hit_q <= 1'b0;
        else if ((state == ST_RELEASE) || core_req_ok) bp_hit_q <= 1'b0;
        else if (bp_stop)                           bp_hit_q <= 1'b1;
    end

    // Enabled core cycles since the last program release, saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    run_cnt_q <= '0;
        else if (state == ST_RELEASE) run_cnt_q <= '0;
        else if (core_clk_en)       run_cnt_q <= sat_inc(run_cnt_q);
    end

    assign imem_waddr = waddr_q;
    assign imem_wdata = wdata_q;
    assign bp_hit     = bp_hit_q;
    assign run_cycles = run_cnt_q;

endmodule

// File: tb/tb_core_boot_ctrl.sv
// Directed bench for core_boot_ctrl: write scoreboard, cycle-counter model,
// a tiny fake core that advances its PC on each enabled cycle.
module tb_core_boot_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start;
    logic [3:0]  load_len;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [3:0]  imem_waddr;
    logic [15:0] imem_wdata;
    logic        run_req, halt_req, step_req, bp_en;
    logic [7:0]  bp_addr;
    logic [7:0]  core_pc;
    logic        core_rst, core_clk_en, loaded, bp_hit;
    logic [15:0] run_cycles;

    core_boot_ctrl #(.IMEM_AW(4), .INSTR_W(16), .PC_W(8)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .load_len(load_len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
        .bp_en(bp_en), .bp_addr(bp_addr), .core_pc(core_pc),
        .core_rst(core_rst), .core_clk_en(core_clk_en), .loaded(loaded),
        .bp_hit(bp_hit), .run_cycles(run_cycles)
    );

    always #5 clk = ~clk;

    // Fake core: PC held at 0 in reset, advances once per enabled cycle.
    always @(posedge clk or posedge rst) begin
        if (rst)              core_pc <= 8'h00;
        else if (core_rst)    core_pc <= 8'h00;
        else if (core_clk_en) core_pc <= core_pc + 8'h01;
    end

    typedef struct { logic [3:0] addr; logic [15:0] data; } wr_t;
    wr_t         exp_q[$];
    logic [7:0]  prog [32];
    int          vectors = 0;
    int          miscompares = 0;
    int          wr_cnt = 0;
    int          mon_cnt = 0;
    logic [3:0]  last_wr_addr;
    logic [15:0] last_wr_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every write must match the expected program image in
    // order; while the program is loaded run_cycles equals enabled cycles so far.
    always @(negedge clk) begin
        if (rst) begin
            mon_cnt = 0;
        end else begin
            if (imem_we) begin
                wr_cnt++;
                last_wr_addr = imem_waddr;
                last_wr_data = imem_wdata;
                if (exp_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected_write: got addr %0h data %0h expected none", imem_waddr, imem_wdata);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_addr", imem_waddr, e.addr);
                    chk("wr_data", imem_wdata, e.data);
                end
                chk("we_without_ready", in_ready, 1'b0);
            end
            if (loaded) begin
                chk("run_cycles_model", run_cycles, mon_cnt);
                if (core_clk_en) mon_cnt++;
            end else begin
                mon_cnt = 0;
            end
        end
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_core_rst"},    core_rst,    1'b1);
        chk({tag, "_clk_en"},      core_clk_en, 1'b0);
        chk({tag, "_in_ready"},    in_ready,    1'b0);
        chk({tag, "_imem_we"},     imem_we,     1'b0);
        chk({tag, "_waddr"},       imem_waddr,  4'h0);
        chk({tag, "_wdata"},       imem_wdata,  16'h0);
        chk({tag, "_loaded"},      loaded,      1'b0);
        chk({tag, "_bp_hit"},      bp_hit,      1'b0);
        chk({tag, "_run_cycles"},  run_cycles,  16'h0);
    endtask

    // Caller is one tick after a rising edge, in IDLE or HALT. Returns the
    // number of edges from the load_start sampling edge until HALT.
    task automatic do_load(input int len, input int gap_mod, input bit poke, output int cyc);
        int nw, idx;
        bit hs;
        nw = (len == 0) ? 16 : len;
        for (int w = 0; w < nw; w++) begin
            wr_t e;
            e.addr = 4'(w);
            e.data = {prog[2*w], prog[2*w+1]};
            exp_q.push_back(e);
        end
        load_start = 1'b1;
        load_len   = 4'(len);
        @(posedge clk); #1;
        load_start = 1'b0;
        idx = 0;
        cyc = 0;
        while (cyc < 400) begin
            in_valid = (idx < 2*nw) && !(gap_mod != 0 && (cyc % gap_mod) == gap_mod - 1);
            in_data  = in_valid ? prog[idx] : 8'hA5;
            @(negedge clk);
            if (loaded) break;
            hs = in_valid && in_ready;
            if (poke && imem_we) load_start = 1'b1;
            @(posedge clk); #1;
            load_start = 1'b0;
            cyc++;
            if (hs) idx++;
        end
        in_valid = 1'b0;
        chk("load_timeout", (cyc < 400), 1'b1);
        chk("load_all_written", exp_q.size(), 0);
    endtask

    task automatic tick;
        @(posedge clk); #1;
    endtask

    initial begin
        int cyc, en_cnt, w0;
        rst = 1'b1; load_start = 0; load_len = 0; in_valid = 0; in_data = 0;
        run_req = 0; halt_req = 0; step_req = 0; bp_en = 0; bp_addr = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset("por");
        tick; rst = 1'b0;
        // Stays idle without load_start, even with stray requests.
        run_req = 1; step_req = 1; in_valid = 1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_hold_in_ready", in_ready, 1'b0);
            chk("idle_hold_core_rst", core_rst, 1'b1);
            tick;
        end
        run_req = 0; step_req = 0; in_valid = 0;

        // Two-word load at full rate.
        prog[0] = 8'h12; prog[1] = 8'h34; prog[2] = 8'h56; prog[3] = 8'h78;
        w0 = wr_cnt;
        do_load(2, 0, 0, cyc);
        chk("load2_latency", cyc, 7);
        chk("load2_writes", wr_cnt - w0, 2);
        chk("load2_last_data", last_wr_data, 16'h5678);
        chk("load2_loaded", loaded, 1'b1);
        chk("load2_core_rst", core_rst, 1'b0);
        chk("load2_run_cycles", run_cycles, 16'h0);

        // Three single steps.
        for (int k = 0; k < 3; k++) begin
            tick; step_req = 1;
            @(negedge clk); chk("step_pre_en", core_clk_en, 1'b0);
            tick; step_req = 0;
            @(negedge clk); chk("step_en", core_clk_en, 1'b1);
            tick;
            @(negedge clk); chk("step_post_en", core_clk_en, 1'b0);
        end
        chk("step_run_cycles", run_cycles, 16'd3);
        chk("step_pc", core_pc, 8'd3);

        // Breakpoint at 0x06.
        bp_en = 1; bp_addr = 8'h06;
        tick; run_req = 1;
        @(negedge clk);
        tick; run_req = 0;
        en_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (core_pc == 8'h06) break;
            if (core_clk_en) en_cnt++;
            tick;
        end
        chk("bp_pc_reached", core_pc, 8'h06);
        chk("bp_clk_en_low", core_clk_en, 1'b0);
        chk("bp_run_en_cnt", en_cnt, 3);
        tick;
        @(negedge clk);
        chk("bp_hit_set", bp_hit, 1'b1);
        chk("bp_halted_en", core_clk_en, 1'b0);
        chk("bp_loaded", loaded, 1'b1);
        chk("bp_run_cycles", run_cycles, 16'd6);
        tick;
        @(negedge clk);
        chk("bp_hold_pc", core_pc, 8'h06);
        chk("bp_hit_sticky", bp_hit, 1'b1);
        // Resume from the breakpoint PC must advance.
        tick; run_req = 1;
        @(negedge clk);
        tick; run_req = 0;
        @(negedge clk);
        chk("resume_en", core_clk_en, 1'b1);
        chk("resume_bp_clr", bp_hit, 1'b0);
        chk("resume_pc", core_pc, 8'h06);
        tick; halt_req = 1;
        @(negedge clk);
        chk("halt_req_cycle_en", core_clk_en, 1'b1);
        chk("halt_req_cycle_pc", core_pc, 8'h07);
        tick; halt_req = 0;
        @(negedge clk);
        chk("halted_en", core_clk_en, 1'b0);
        chk("halted_pc", core_pc, 8'h08);
        chk("halted_run_cycles", run_cycles, 16'd8);

        // All three requests together: step wins.
        tick; halt_req = 1; step_req = 1; run_req = 1;
        @(negedge clk);
        tick; halt_req = 0; step_req = 0; run_req = 0;
        @(negedge clk); chk("prio_step_en", core_clk_en, 1'b1);
        tick;
        @(negedge clk); chk("prio_after_en", core_clk_en, 1'b0);
        chk("prio_pc", core_pc, 8'h09);

        // load_start pulsed during WRITE cycles is ignored.
        bp_en = 0;
        prog[0] = 8'hDE; prog[1] = 8'hAD; prog[2] = 8'hBE; prog[3] = 8'hEF;
        tick;
        w0 = wr_cnt;
        do_load(2, 0, 1, cyc);
        chk("poke_latency", cyc, 7);
        chk("poke_writes", wr_cnt - w0, 2);
        chk("poke_last_addr", last_wr_addr, 4'h1);

        // Full 16-word load with in_valid gaps.
        for (int i = 0; i < 32; i++) prog[i] = 8'(i * 29 + 7);
        tick;
        w0 = wr_cnt;
        do_load(0, 5, 0, cyc);
        chk("full_writes", wr_cnt - w0, 16);
        chk("full_last_addr", last_wr_addr, 4'hF);
        chk("full_last_data", last_wr_data, {8'(30*29+7), 8'(31*29+7)});
        chk("full_loaded", loaded, 1'b1);

        // Reset while waiting for the low byte.
        tick; load_start = 1; load_len = 4'd2;
        tick; load_start = 0; in_valid = 1; in_data = 8'hAB;
        tick; in_valid = 0;
        rst = 1; #1;
        chk_reset("rst_load_lo");
        tick; rst = 0; in_valid = 1; in_data = 8'h11;
        w0 = wr_cnt;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_idle_ready", in_ready, 1'b0);
            tick;
        end
        in_valid = 0;
        chk("post_rst_no_write", wr_cnt - w0, 0);

        // Reset while halted on a breakpoint, then while running.
        prog[0] = 8'h9A; prog[1] = 8'hBC;
        do_load(1, 0, 0, cyc);
        chk("load1_latency", cyc, 4);
        bp_en = 1; bp_addr = 8'h02;
        tick; run_req = 1;
        tick; run_req = 0;
        repeat (6) tick;
        @(negedge clk);
        chk("bp2_hit", bp_hit, 1'b1);
        chk("bp2_pc", core_pc, 8'h02);
        chk("bp2_run_cycles", run_cycles, 16'd2);
        tick; rst = 1; #1;
        chk_reset("rst_halt");
        tick; rst = 0; bp_en = 0;
        do_load(1, 0, 0, cyc);
        tick; run_req = 1;
        tick; run_req = 0;
        repeat (3) tick;
        chk("run_before_rst_en", core_clk_en, 1'b1);
        rst = 1; #1;
        chk_reset("rst_run");
        tick; rst = 0;
        @(negedge clk);
        chk("post_run_rst_loaded", loaded, 1'b0);
        chk("post_run_rst_pc", core_pc, 8'h00);
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
